// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one CHUNK-bit carry chain, LSB chunk first.
// Define ADDER_SUB_EN to add the sub port (a - b via ~b and a forced carry-in of 1).
module chunked_serial_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready is high only in IDLE, out_valid only in DONE; both decode the state register.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] a_shift;

`ifdef ADDER_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : carryin;
`else
    assign b_eff = b;
    assign c_eff = carryin;
`endif

    // The only carry path between chunks is c_q.
    assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(c_q);

    // a_q doubles as the result shift register: operand chunks leave at the bottom,
    // sum chunks enter at the top, so after NCHUNK steps it holds the full sum.
    assign a_shift = (a_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_eff;
                    c_d     = c_eff;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                a_d   = a_shift;
                b_d   = b_q >> CHUNK;
                c_d   = chunk_sum[CHUNK];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    // On the last step a_q/b_q still hold the operand sign bits.
                    sum_d   = a_shift;
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = (a_q[CHUNK-1] == b_q[CHUNK-1]) &&
                              (chunk_sum[CHUNK-1] != a_q[CHUNK-1]);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign carryout  = cout_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder: random and directed operations against an
// arithmetic reference model, with a queue-based scoreboard and a free-running monitor.
module tb_chunked_serial_adder;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int RW     = WIDTH + 2;
    typedef logic [RW-1:0] rw_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             cin_in = 1'b0;
`ifdef ADDER_SUB_EN
    logic             sub_in = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;
    logic [1:0]       dbg_state;

    chunked_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
        .carryin   (cin_in),
`ifdef ADDER_SUB_EN
        .sub       (sub_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carryout  (carryout),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- scoreboard state ----------------
    rw_t exp_q[$];           // {overflow, carryout, sum}
    int  checks = 0;
    int  failures = 0;
    int  accept_cyc = 0;
    bit  rand_ready = 1'b0;
    bit  forced_ready = 1'b1;

    task automatic chk(input string name, input rw_t act, input rw_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain (WIDTH+1)-bit addition of a, the effective b and the carry-in.
    function automatic rw_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin, input logic s);
        logic [WIDTH-1:0] be;
        logic             ci;
        logic [WIDTH:0]   full;
        logic             ovf;
        be   = s ? ~b : b;
        ci   = s ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, be} + (WIDTH+1)'(ci);
        ovf  = (a[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return {ovf, full[WIDTH], full[WIDTH-1:0]};
    endfunction

    // out_ready changes just after the rising edge so the monitor sees a settled value.
    initial forever begin
        @(posedge clk);
        #2;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : forced_ready;
    end

    // ---------------- monitor ----------------
    initial begin
        rw_t cur;
        rw_t prev_out;
        bit  have_prev;
        bit  prev_ov;
        have_prev = 1'b0;
        prev_ov   = 1'b0;
        prev_out  = '0;
        forever begin
            @(negedge clk);
            cur = {overflow, carryout, sum};
            if (!rst_n) begin
                have_prev = 1'b0;
                prev_ov   = 1'b0;
            end else begin
                if (out_valid)
                    chk("in_ready_low_in_done", rw_t'(in_ready), rw_t'(0));
                if (out_valid && !prev_ov)
                    chk("latency", rw_t'(cyc - accept_cyc), rw_t'(NCHUNK));
                if (have_prev && !(out_valid && !prev_ov))
                    chk("outputs_stable", cur, prev_out);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result: got %h expected none", cur);
                    end else begin
                        chk("result", cur, exp_q.pop_front());
                    end
                end
                prev_out  = cur;
                have_prev = 1'b1;
                prev_ov   = out_valid;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic s, input bit expect_it);
        int n;
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        cin_in   = cin;
`ifdef ADDER_SUB_EN
        sub_in   = s;
`endif
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", rw_t'(in_ready), rw_t'(1));
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        accept_cyc = cyc;
        if (expect_it) exp_q.push_back(model(a, b, cin, s));
        in_valid = 1'b0;
        a_in     = WIDTH'($urandom);
        b_in     = WIDTH'($urandom);
        cin_in   = 1'($urandom_range(0, 1));
`ifdef ADDER_SUB_EN
        sub_in   = 1'($urandom_range(0, 1));
`endif
        chk("in_ready_drop", rw_t'(in_ready), rw_t'(0));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", rw_t'(exp_q.size()), rw_t'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int               n;
        logic [WIDTH-1:0] ra, rb;
        logic             rs;

        repeat (3) @(negedge clk);
        chk("reset_in_ready", rw_t'(in_ready), rw_t'(1));
        chk("reset_out_valid", rw_t'(out_valid), rw_t'(0));
        chk("reset_outputs", {overflow, carryout, sum}, rw_t'(0));
        #3 rst_n = 1'b1;

        send(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 1'b1);
        drain();
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        drain();

        // Hold the result; a new request during DONE must be ignored.
        forced_ready = 1'b0;
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                a_in     = 32'hDEAD_BEEF;
                b_in     = 32'h0BAD_F00D;
                in_valid = 1'b1;
            end
            chk("hold_out_valid", rw_t'(out_valid), rw_t'(1));
        end
        in_valid     = 1'b0;
        forced_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", rw_t'(in_ready), rw_t'(1));
        chk("release_out_valid", rw_t'(out_valid), rw_t'(0));
        repeat (3) @(negedge clk);
        chk("ignored_req_in_ready", rw_t'(in_ready), rw_t'(1));

        // Random operations with random back-pressure and corner operand classes.
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: ra = '1;
                1: ra = {1'b0, {(WIDTH-1){1'b1}}};
                2: ra = {1'b1, {(WIDTH-1){1'b0}}};
                default: ra = WIDTH'($urandom);
            endcase
            rb = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
`ifdef ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            send(ra, rb, 1'($urandom_range(0, 1)), rs, 1'b1);
        end
        drain();
        rand_ready   = 1'b0;
        forced_ready = 1'b1;

`ifdef ADDER_SUB_EN
        send(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1);
        drain();
`endif

        // Abort an operation with reset in its second compute cycle.
        send(32'h0000_1234, 32'h0000_1111, 1'b0, 1'b0, 1'b1);
        drain();
        send(32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", rw_t'(out_valid), rw_t'(0));
        chk("abort_in_ready", rw_t'(in_ready), rw_t'(1));
        chk("abort_outputs", {overflow, carryout, sum}, rw_t'(0));
        @(negedge clk);
        #3 rst_n = 1'b1;
        send(32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
        drain();

        repeat (NCHUNK + 4) @(negedge clk);
        chk("final_out_valid", rw_t'(out_valid), rw_t'(0));
        chk("final_queue_empty", rw_t'(exp_q.size()), rw_t'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
        $fatal(1, "global timeout");
    end

endmodule
